display_sequencer: RTL

Parametrised successor to the Bulls & Cows display manager. It drives `NUM_DIGITS` 6-bit character codes from the game state. It adds four things:

- Registered result digits showing the latched bull and cow counts.
- A timed result hold with a completion pulse to the game FSM.
- Blinking on WIN.
- A circular scrolling message on FIM.

It sits between the game FSM and the character-to-segment decoders.

---
 rtl/display_sequencer.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/display_sequencer.sv
// Character sequencer for the Bulls & Cows display: static text per game state,
// latched result digits with a timed hold, WIN blinking and the FIM scrolling banner.
module display_sequencer #(
  parameter int unsigned NUM_DIGITS    = 8,
  parameter int unsigned BLINK_CYCLES  = 25_000_000,
  parameter int unsigned SCROLL_CYCLES = 12_500_000,
  parameter int unsigned HOLD_CYCLES   = 100_000_000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [2:0]               state,
  input  logic                     winner,
  input  logic [3:0]               bulls,
  input  logic [3:0]               cows,
  input  logic                     result_valid,
  output logic [NUM_DIGITS*6-1:0]  d,
  output logic                     hold_done,
  output logic                     busy
);

  localparam int unsigned CW       = 6;
  localparam int unsigned DW       = NUM_DIGITS * CW;
  localparam int unsigned TEXT_LEN = 8;
  localparam int unsigned RING_LEN = 12;
  localparam int unsigned BCW      = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam int unsigned SCW      = (SCROLL_CYCLES > 1) ? $clog2(SCROLL_CYCLES) : 1;
  localparam int unsigned HCW      = $clog2(HOLD_CYCLES + 1);

  localparam logic [2:0] ST_SECRET_J1 = 3'd0;
  localparam logic [2:0] ST_SECRET_J2 = 3'd1;
  localparam logic [2:0] ST_GUESS_J1  = 3'd2;
  localparam logic [2:0] ST_GUESS_J2  = 3'd3;
  localparam logic [2:0] ST_RESULT_J1 = 3'd4;
  localparam logic [2:0] ST_RESULT_J2 = 3'd5;
  localparam logic [2:0] ST_WIN       = 3'd6;
  localparam logic [2:0] ST_FIM       = 3'd7;

  localparam logic [CW-1:0] C_BLANK = 6'b100000;
  localparam logic [CW-1:0] C_J = 6'b001011;
  localparam logic [CW-1:0] C_S = 6'b000101;
  localparam logic [CW-1:0] C_E = 6'b001110;
  localparam logic [CW-1:0] C_T = 6'b000111;
  localparam logic [CW-1:0] C_U = 6'b001100;
  localparam logic [CW-1:0] C_P = 6'b001101;
  localparam logic [CW-1:0] C_G = 6'b000110;
  localparam logic [CW-1:0] C_B = 6'b001000;
  localparam logic [CW-1:0] C_L = 6'b001001;
  localparam logic [CW-1:0] C_Y = 6'b000100;
  localparam logic [CW-1:0] C_A = 6'b001010;
  localparam logic [CW-1:0] C_O = 6'b001111;
  localparam logic [CW-1:0] C_V = 6'b010000;
  localparam logic [CW-1:0] C_F = 6'b010001;
  localparam logic [CW-1:0] C_I = 6'b010010;
  localparam logic [CW-1:0] C_M = 6'b010011;

  function automatic logic [CW-1:0] digit_code(input logic [3:0] n);
    return {2'b11, n};
  endfunction

  function automatic logic [3:0] sat9(input logic [3:0] n);
    return (n > 4'd9) ? 4'd9 : n;
  endfunction

  logic [2:0]     state_q;
  logic [3:0]     b_q, c_q, b_nxt, c_nxt;
  logic [HCW-1:0] hold_cnt, hold_nxt;
  logic           busy_nxt, done_nxt;
  logic [BCW-1:0] blink_cnt, blink_cnt_nxt;
  logic           blink_on, blink_on_nxt;
  logic [SCW-1:0] scroll_cnt, scroll_cnt_nxt;
  logic [3:0]     k_q, k_nxt;
  logic [DW-1:0]  d_nxt;
  logic           state_chg, in_result;
  logic [4:0]     idx;
  logic [CW-1:0]  jn, win_dig;
  logic [CW-1:0]  ch   [TEXT_LEN];
  logic [CW-1:0]  ring [RING_LEN];

  assign state_chg = (state != state_q);
  assign in_result = (state == ST_RESULT_J1) || (state == ST_RESULT_J2);

  // Result latch and hold timer; a restart takes priority over expiry
  always_comb begin
    b_nxt    = b_q;
    c_nxt    = c_q;
    hold_nxt = hold_cnt;
    busy_nxt = busy;
    done_nxt = 1'b0;
    if (result_valid && in_result) begin
      b_nxt    = sat9(bulls);
      c_nxt    = sat9(cows);
      hold_nxt = HCW'(HOLD_CYCLES);
      busy_nxt = 1'b1;
      done_nxt = (HOLD_CYCLES == 32'd1);
    end else if (busy && !in_result) begin
      busy_nxt = 1'b0;
    end else if (busy) begin
      if (hold_cnt == HCW'(1)) begin
        busy_nxt = 1'b0;
      end else begin
        hold_nxt = hold_cnt - HCW'(1);
        done_nxt = (hold_cnt == HCW'(2));
      end
    end
  end

  // Blink and scroll dividers, restarted on every state change
  always_comb begin
    blink_cnt_nxt  = blink_cnt;
    blink_on_nxt   = blink_on;
    scroll_cnt_nxt = scroll_cnt;
    k_nxt          = k_q;
    if (state_chg) begin
      blink_cnt_nxt  = '0;
      blink_on_nxt   = 1'b1;
      scroll_cnt_nxt = '0;
      k_nxt          = 4'd0;
    end else if (state == ST_WIN) begin
      if (blink_cnt == BCW'(BLINK_CYCLES - 1)) begin
        blink_cnt_nxt = '0;
        blink_on_nxt  = !blink_on;
      end else begin
        blink_cnt_nxt = blink_cnt + BCW'(1);
      end
    end else if (state == ST_FIM) begin
      if (scroll_cnt == SCW'(SCROLL_CYCLES - 1)) begin
        scroll_cnt_nxt = '0;
        k_nxt          = (k_q == 4'd11) ? 4'd0 : k_q + 4'd1;
      end else begin
        scroll_cnt_nxt = scroll_cnt + SCW'(1);
      end
    end
  end

  // Character selection for the next display word
  always_comb begin
    jn      = state[0] ? digit_code(4'd2) : digit_code(4'd1);
    win_dig = winner ? digit_code(4'd2) : digit_code(4'd1);
    ring    = '{C_F, C_I, C_M, C_BLANK, C_J, win_dig, C_BLANK, C_B, C_U, C_L, C_L, C_S};
    idx     = '0;
    for (int i = 0; i < TEXT_LEN; i++) ch[i] = C_BLANK;
    case (state)
      ST_SECRET_J1, ST_SECRET_J2:
        ch = '{C_J, jn, C_BLANK, C_S, C_E, C_T, C_U, C_P};
      ST_GUESS_J1, ST_GUESS_J2:
        ch = '{C_J, jn, C_BLANK, C_G, C_U, C_E, C_S, C_S};
      ST_RESULT_J1, ST_RESULT_J2:
        ch = '{digit_code(b_nxt), C_BLANK, C_T, C_O, digit_code(c_nxt), C_BLANK, C_V, C_A};
      ST_WIN:
        if (blink_on_nxt) ch = '{C_B, C_U, C_L, C_L, C_S, C_E, C_Y, C_E};
      ST_FIM:
        for (int i = 0; i < TEXT_LEN; i++) begin
          idx = 5'(k_nxt) + 5'(i);
          if (idx >= 5'd12) idx = idx - 5'd12;
          ch[i] = ring[idx[3:0]];
        end
      default: ;
    endcase
    d_nxt = {NUM_DIGITS{C_BLANK}};
    for (int i = 0; i < TEXT_LEN; i++) d_nxt[i*CW +: CW] = ch[i];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_SECRET_J1;
      b_q        <= 4'd0;
      c_q        <= 4'd0;
      hold_cnt   <= '0;
      busy       <= 1'b0;
      hold_done  <= 1'b0;
      blink_cnt  <= '0;
      blink_on   <= 1'b1;
      scroll_cnt <= '0;
      k_q        <= 4'd0;
      d          <= {NUM_DIGITS{C_BLANK}};
    end else begin
      state_q    <= state;
      b_q        <= b_nxt;
      c_q        <= c_nxt;
      hold_cnt   <= hold_nxt;
      busy       <= busy_nxt;
      hold_done  <= done_nxt;
      blink_cnt  <= blink_cnt_nxt;
      blink_on   <= blink_on_nxt;
      scroll_cnt <= scroll_cnt_nxt;
      k_q        <= k_nxt;
      d          <= d_nxt;
    end
  end

endmodule
